// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART receiver and transmitter.
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_PAR   = 3'd3,
      ST_STOP  = 3'd4
   } rx_state_e;

   // Bits needed to hold values 0..value-1.
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: rx synchroniser plus 3-sample majority vote around mid-bit.
// bit_val is meaningful in the cycle where s = OVS/2+1 and s_tick is high; the
// third vote is the live rxs value at that tick.
module uart_rx_sampler
   import uart_pkg::*;
#(
   parameter  int OVS         = 16,
   parameter  int SYNC_STAGES = 2,
   localparam int SW          = clog2(OVS)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          rx,
   input  logic          s_tick,
   input  logic [SW-1:0] s,
   output logic          rxs,
   output logic          bit_val
);

   localparam logic [SW-1:0] S_SMP0 = SW'(OVS / 2 - 1);
   localparam logic [SW-1:0] S_SMP1 = SW'(OVS / 2);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [1:0]             smp_q, smp_d;

   // Shift the raw line through the synchroniser; capture the first two votes.
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rx};
      smp_d  = smp_q;
      if (s_tick && (s == S_SMP0)) smp_d[0] = rxs;
      if (s_tick && (s == S_SMP1)) smp_d[1] = rxs;
   end

   // Synchroniser and vote registers; idle-high on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '1;
         smp_q  <= '1;
      end else begin
         sync_q <= sync_d;
         smp_q  <= smp_d;
      end
   end

   assign rxs     = sync_q[SYNC_STAGES-1];
   assign bit_val = (smp_q[0] & smp_q[1]) | (smp_q[0] & rxs) | (smp_q[1] & rxs);

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: oversampled UART receiver with parity, framing, break and
// overrun detection, delivering words through a one-entry valid/ready register.
//
// state | meaning
// IDLE  | line idle; wait for rxs low (or for rxs high after a break)
// START | qualify start bit; a majority 1 is a glitch and returns to IDLE
// DATA  | shift DBIT data bits in, LSB first
// PAR   | check the parity bit
// STOP  | check stop bit(s); the final stop vote completes the frame
module uart_rx_frame
   import uart_pkg::*;
#(
   parameter int DBIT        = 8,
   parameter int OVS         = 16,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            rx,
   input  logic            s_tick,
   output logic [DBIT-1:0] dout,
   output logic            dout_valid,
   input  logic            dout_ready,
   output logic            dout_frame_err,
   output logic            dout_parity_err,
   output logic            dout_break,
   output logic            overrun,
   output logic            busy
);

   localparam int SW = clog2(OVS);
   localparam int NW = clog2(DBIT + 1);

   localparam logic [SW-1:0] S_VOTE  = SW'(OVS / 2 + 1);
   localparam logic [SW-1:0] S_LAST  = SW'(OVS - 1);
   localparam logic [NW-1:0] N_DLAST = NW'(DBIT - 1);
   localparam logic [NW-1:0] N_SLAST = NW'(STOP_BITS - 1);
   localparam logic          ODD     = (PARITY == PAR_ODD);

   rx_state_e       state_q, state_d;
   logic [SW-1:0]   s_q, s_d;
   logic [NW-1:0]   n_q, n_d;
   logic [DBIT-1:0] data_q, data_d;
   logic            par_err_q, par_err_d;
   logic            frm_err_q, frm_err_d;
   logic            par_zero_q, par_zero_d;
   logic            stop0_q, stop0_d;
   logic            wait_high_q, wait_high_d;

   logic [DBIT-1:0] dout_q, dout_d;
   logic            dout_valid_q, dout_valid_d;
   logic            fe_q, fe_d;
   logic            pe_q, pe_d;
   logic            brk_q, brk_d;
   logic            overrun_q, overrun_d;

   logic rxs, bit_val, vote, last, complete, frm_now, brk_now, load;

   uart_rx_sampler #(
      .OVS         (OVS),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sampler (
      .clk     (clk),
      .rst_n   (rst_n),
      .rx      (rx),
      .s_tick  (s_tick),
      .s       (s_q),
      .rxs     (rxs),
      .bit_val (bit_val)
   );

   assign vote = s_tick && (s_q == S_VOTE);
   assign last = s_tick && (s_q == S_LAST);

   // Frame sequencing: bit timing, data shift and pending error flags.
   always_comb begin
      state_d     = state_q;
      s_d         = s_q;
      n_d         = n_q;
      data_d      = data_q;
      par_err_d   = par_err_q;
      frm_err_d   = frm_err_q;
      par_zero_d  = par_zero_q;
      stop0_d     = stop0_q;
      wait_high_d = wait_high_q;
      complete    = 1'b0;
      frm_now     = frm_err_q;
      brk_now     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            s_d = '0;
            n_d = '0;
            if (wait_high_q) begin
               if (rxs) wait_high_d = 1'b0;
            end else if (!rxs) begin
               state_d    = ST_START;
               par_err_d  = 1'b0;
               frm_err_d  = 1'b0;
               par_zero_d = 1'b1;
               stop0_d    = 1'b0;
            end
         end
         ST_START: begin
            if (vote && bit_val) begin
               state_d = ST_IDLE;
               s_d     = '0;
            end else if (last) begin
               state_d = ST_DATA;
               s_d     = '0;
               n_d     = '0;
            end else if (s_tick) begin
               s_d = s_q + SW'(1);
            end
         end
         ST_DATA: begin
            if (vote) data_d = {bit_val, data_q[DBIT-1:1]};
            if (last) begin
               s_d = '0;
               if (n_q == N_DLAST) begin
                  n_d     = '0;
                  state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
               end else begin
                  n_d = n_q + NW'(1);
               end
            end else if (s_tick) begin
               s_d = s_q + SW'(1);
            end
         end
         ST_PAR: begin
            if (vote) begin
               par_zero_d = !bit_val;
               if (bit_val != ((^data_q) ^ ODD)) par_err_d = 1'b1;
            end
            if (last) begin
               s_d     = '0;
               state_d = ST_STOP;
            end else if (s_tick) begin
               s_d = s_q + SW'(1);
            end
         end
         ST_STOP: begin
            if (vote) begin
               if (!bit_val) frm_err_d = 1'b1;
               if (n_q == '0) stop0_d = !bit_val;
               if (n_q == N_SLAST) begin
                  // Finish at mid-bit so a back-to-back start edge is not missed.
                  complete    = 1'b1;
                  frm_now     = frm_err_q | !bit_val;
                  brk_now     = (data_q == '0) && par_zero_q &&
                                ((n_q == '0) ? !bit_val : stop0_q);
                  wait_high_d = brk_now;
                  state_d     = ST_IDLE;
                  s_d         = '0;
                  n_d         = '0;
               end else begin
                  s_d = s_q + SW'(1);
               end
            end else if (last) begin
               s_d = '0;
               n_d = n_q + NW'(1);
            end else if (s_tick) begin
               s_d = s_q + SW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Holding register: load on completion unless a full word is being kept.
   always_comb begin
      load         = complete && (!dout_valid_q || dout_ready);
      dout_d       = dout_q;
      dout_valid_d = dout_valid_q;
      fe_d         = fe_q;
      pe_d         = pe_q;
      brk_d        = brk_q;
      overrun_d    = complete && !load;
      if (dout_valid_q && dout_ready) dout_valid_d = 1'b0;
      if (load) begin
         dout_d       = data_q;
         dout_valid_d = 1'b1;
         fe_d         = frm_now;
         pe_d         = par_err_q;
         brk_d        = brk_now;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         s_q          <= '0;
         n_q          <= '0;
         data_q       <= '0;
         par_err_q    <= 1'b0;
         frm_err_q    <= 1'b0;
         par_zero_q   <= 1'b0;
         stop0_q      <= 1'b0;
         wait_high_q  <= 1'b0;
         dout_q       <= '0;
         dout_valid_q <= 1'b0;
         fe_q         <= 1'b0;
         pe_q         <= 1'b0;
         brk_q        <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         s_q          <= s_d;
         n_q          <= n_d;
         data_q       <= data_d;
         par_err_q    <= par_err_d;
         frm_err_q    <= frm_err_d;
         par_zero_q   <= par_zero_d;
         stop0_q      <= stop0_d;
         wait_high_q  <= wait_high_d;
         dout_q       <= dout_d;
         dout_valid_q <= dout_valid_d;
         fe_q         <= fe_d;
         pe_q         <= pe_d;
         brk_q        <= brk_d;
         overrun_q    <= overrun_d;
      end
   end

   assign dout            = dout_q;
   assign dout_valid      = dout_valid_q;
   assign dout_frame_err  = fe_q;
   assign dout_parity_err = pe_q;
   assign dout_break      = brk_q;
   assign overrun         = overrun_q;
   assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: two receivers (A = 8N1, B = 8E2), directed vector table,
// hand-written corner sequences and randomized frames against a line-level model.
module tb_uart_rx_frame;

   localparam int OVS = 16;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       brk;
   } word_t;

   typedef struct {
      int         which;
      logic [7:0] d;
      logic       par;
      logic       st1;
      logic       st2;
      word_t      exp;
   } vec_t;

   logic clk = 1'b0, rst_n = 1'b0, s_tick = 1'b0;
   logic rx_a = 1'b1, rx_b = 1'b1, rdy_a = 1'b1, rdy_b = 1'b1;
   logic [7:0] dout_a, dout_b;
   logic val_a, fe_a, pe_a, brk_a, ovr_a, busy_a;
   logic val_b, fe_b, pe_b, brk_b, ovr_b, busy_b;

   int checks = 0, errors = 0;
   int bit_clk = 2 * OVS;
   logic tick_cont = 1'b0;
   word_t got_a[$], got_b[$];
   int vcyc_a = 0, vcyc_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;
   vec_t vecs[11];

   uart_rx_frame #(.DBIT(8), .OVS(OVS), .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a), .s_tick(s_tick), .dout(dout_a),
      .dout_valid(val_a), .dout_ready(rdy_a), .dout_frame_err(fe_a),
      .dout_parity_err(pe_a), .dout_break(brk_a), .overrun(ovr_a), .busy(busy_a));

   uart_rx_frame #(.DBIT(8), .OVS(OVS), .PARITY(1), .STOP_BITS(2), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b), .s_tick(s_tick), .dout(dout_b),
      .dout_valid(val_b), .dout_ready(rdy_b), .dout_frame_err(fe_b),
      .dout_parity_err(pe_b), .dout_break(brk_b), .overrun(ovr_b), .busy(busy_b));

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      s_tick = tick_cont ? 1'b1 : ~s_tick;
   end

   // Monitor: sample just before each rising edge, record accepted words.
   always @(negedge clk) begin
      #3;
      if (val_a && rdy_a) got_a.push_back({dout_a, pe_a, fe_a, brk_a});
      if (val_b && rdy_b) got_b.push_back({dout_b, pe_b, fe_b, brk_b});
      if (val_a) vcyc_a++;
      if (val_b) vcyc_b++;
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Expected word from the frame as placed on the wire.
   function automatic word_t model(input int which, input logic [7:0] d, input logic par,
                                   input logic st1, input logic st2);
      word_t w;
      w.d   = d;
      w.pe  = (which == 1) && (par != (^d));
      w.fe  = !st1 || ((which == 1) && !st2);
      w.brk = (d == 8'h00) && ((which == 0) || !par) && !st1;
      return w;
   endfunction

   task automatic drive_bit(input int which, input logic v);
      if (which == 0) rx_a = v; else rx_b = v;
      repeat (bit_clk) @(negedge clk);
   endtask

   task automatic send_frame(input int which, input logic [7:0] d, input logic par,
                             input logic st1, input logic st2);
      drive_bit(which, 1'b0);
      for (int i = 0; i < 8; i++) drive_bit(which, d[i]);
      if (which == 1) drive_bit(which, par);
      drive_bit(which, st1);
      if (which == 1) drive_bit(which, st2);
      if (which == 0) rx_a = 1'b1; else rx_b = 1'b1;
      repeat (bit_clk + int'($urandom_range(0, 20))) @(negedge clk);
   endtask

   task automatic expect_word(input int which, input word_t exp, input string tag);
      word_t w;
      int n;
      n = (which == 0) ? got_a.size() : got_b.size();
      chk({tag, "_count"}, n, 1);
      if (n > 0) begin
         if (which == 0) w = got_a.pop_front(); else w = got_b.pop_front();
         chk({tag, "_dout"}, w.d, exp.d);
         chk({tag, "_parity_err"}, w.pe, exp.pe);
         chk({tag, "_frame_err"}, w.fe, exp.fe);
         chk({tag, "_break"}, w.brk, exp.brk);
      end
      if (which == 0) got_a.delete(); else got_b.delete();
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_dout_a"}, dout_a, 0);
      chk({tag, "_flags_a"}, {val_a, fe_a, pe_a, brk_a, ovr_a, busy_a}, 0);
      chk({tag, "_dout_b"}, dout_b, 0);
      chk({tag, "_flags_b"}, {val_b, fe_b, pe_b, brk_b, ovr_b, busy_b}, 0);
   endtask

   task automatic run_random(input int count, input string tag);
      int which;
      logic [7:0] d;
      logic par, st1, st2;
      for (int i = 0; i < count; i++) begin
         which = int'($urandom_range(0, 1));
         d     = 8'($urandom);
         if ($urandom_range(0, 9) == 0) d = 8'h00;
         par   = (^d) ^ ($urandom_range(0, 3) == 0);
         st1   = ($urandom_range(0, 7) != 0);
         st2   = ($urandom_range(0, 7) != 0);
         vcyc_a = 0;
         vcyc_b = 0;
         send_frame(which, d, par, st1, st2);
         expect_word(which, model(which, d, par, st1, st2), tag);
         chk({tag, "_valid_cycles"}, vcyc_a + vcyc_b, 1);
      end
   endtask

   initial begin
      vecs[0]  = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, {8'hA5, 3'b000}};
      vecs[1]  = '{0, 8'h00, 1'b0, 1'b1, 1'b1, {8'h00, 3'b000}};
      vecs[2]  = '{0, 8'hFF, 1'b0, 1'b0, 1'b1, {8'hFF, 3'b010}};
      vecs[3]  = '{0, 8'h00, 1'b0, 1'b0, 1'b1, {8'h00, 3'b011}};
      vecs[4]  = '{1, 8'h03, 1'b1, 1'b1, 1'b1, {8'h03, 3'b100}};
      vecs[5]  = '{1, 8'h03, 1'b0, 1'b1, 1'b1, {8'h03, 3'b000}};
      vecs[6]  = '{1, 8'h5A, 1'b0, 1'b1, 1'b0, {8'h5A, 3'b010}};
      vecs[7]  = '{1, 8'h5A, 1'b1, 1'b0, 1'b1, {8'h5A, 3'b110}};
      vecs[8]  = '{1, 8'h00, 1'b0, 1'b0, 1'b1, {8'h00, 3'b011}};
      vecs[9]  = '{1, 8'h00, 1'b1, 1'b0, 1'b1, {8'h00, 3'b110}};
      vecs[10] = '{1, 8'h80, 1'b1, 1'b1, 1'b1, {8'h80, 3'b000}};

      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check_reset("reset");

      // Directed vectors, ready held high.
      for (int v = 0; v < 11; v++) begin
         vcyc_a = 0;
         vcyc_b = 0;
         send_frame(vecs[v].which, vecs[v].d, vecs[v].par, vecs[v].st1, vecs[v].st2);
         expect_word(vecs[v].which, vecs[v].exp, $sformatf("vec%0d", v));
         chk($sformatf("vec%0d_valid_cycles", v), vcyc_a + vcyc_b, 1);
      end

      // Start glitch of 5 ticks.
      rx_a = 1'b0;
      repeat (5 * 2) @(negedge clk);
      chk("glitch_busy_set", busy_a, 1);
      rx_a = 1'b1;
      for (int k = 0; k < bit_clk && busy_a; k++) @(negedge clk);
      chk("glitch_busy_drop", busy_a, 0);
      repeat (bit_clk) @(negedge clk);
      chk("glitch_no_word", got_a.size(), 0);

      // Overrun: second word dropped while first is held.
      rdy_a = 1'b0;
      ovr_cnt_a = 0;
      send_frame(0, 8'h11, 1'b0, 1'b1, 1'b1);
      send_frame(0, 8'h22, 1'b0, 1'b1, 1'b1);
      chk("ovr_held_dout", dout_a, 8'h11);
      chk("ovr_held_valid", val_a, 1);
      chk("ovr_pulses", ovr_cnt_a, 1);
      rdy_a = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("ovr_drained_valid", val_a, 0);
      expect_word(0, {8'h11, 3'b000}, "ovr_word");

      // Line held low for 12 bit times: exactly one break word.
      rx_a = 1'b0;
      repeat (12 * bit_clk) @(negedge clk);
      rx_a = 1'b1;
      repeat (2 * bit_clk) @(negedge clk);
      expect_word(0, {8'h00, 3'b011}, "break");

      // Randomized frames, divided ticks then continuous ticks.
      ovr_cnt_a = 0;
      ovr_cnt_b = 0;
      run_random(40, "rnd");
      tick_cont = 1'b1;
      bit_clk = OVS;
      repeat (4) @(negedge clk);
      run_random(16, "rndc");
      chk("rnd_overrun_a", ovr_cnt_a, 0);
      chk("rnd_overrun_b", ovr_cnt_b, 0);

      // Reset in the middle of a frame while a word is held.
      rdy_a = 1'b0;
      send_frame(0, 8'h77, 1'b0, 1'b1, 1'b1);
      chk("mid_held_valid", val_a, 1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      drive_bit(0, 1'b0);
      drive_bit(0, 1'b1);
      chk("mid_busy", busy_a, 1);
      rst_n = 1'b0;
      #1;
      check_reset("midreset");
      rx_a = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      rdy_a = 1'b1;
      repeat (2 * bit_clk) @(negedge clk);
      chk("midreset_no_word", got_a.size(), 0);
      chk("midreset_valid", val_a, 0);
      chk("leftover_b", got_b.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
